fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 7 +
 rtl/exec_watchdog.sv | 18 +
 rtl/fetch_unit.sv | 64 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, halt opcode and fetch FSM state encoding
package cpu_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam logic [DATA_W_DEF-1:0] HALT_OPCODE = '0;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_EXECUTE, S_HALT} state_t;
endpackage

// File: rtl/exec_watchdog.sv
// exec_watchdog: counts enabled cycles from zero and flags when LIMIT is reached
module exec_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] count;
  assign expired = count == W'(LIMIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable && !expired) count <= count + W'(1);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch/load/decode/execute sequencer driving program memory and the decoder strobe
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int EXEC_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              IRin,
  input  logic              exec_done,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              timeout_err
);
  state_t state, state_next;
  logic in_exec, expired, is_halt_op;
  assign in_exec = state == S_EXECUTE;
  assign is_halt_op = instruction == DATA_W'(HALT_OPCODE);
  assign mem_addr = pc;
  exec_watchdog #(.LIMIT(EXEC_TIMEOUT)) u_watchdog (
    .clk, .rst_n, .clear(!in_exec), .enable(in_exec), .expired
  );
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    state_next = run ? S_FETCH : S_IDLE;
      S_FETCH:   state_next = mem_valid ? S_LOAD : S_FETCH;
      S_LOAD:    state_next = S_DECODE;
      S_DECODE:  state_next = is_halt_op ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_next = exec_done ? (run ? S_FETCH : S_IDLE) : expired ? S_HALT : S_EXECUTE;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_IDLE;
    endcase
  end
  // Strobes are registered from the next state so they are glitch-free and aligned with it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      instruction <= '0;
      IRin        <= 1'b0;
      mem_rd      <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state  <= state_next;
      mem_rd <= state_next == S_FETCH;
      IRin   <= state_next == S_LOAD;
      halted <= state_next == S_HALT;
      if (state == S_FETCH && mem_valid) instruction <= mem_rdata;
      if (in_exec && exec_done) pc <= jump_en ? jump_addr : pc + ADDR_W'(1);
      if (in_exec && !exec_done && expired) timeout_err <= 1'b1;
    end
endmodule
